// File: rtl/pipelined_wallace_mult.sv
// Pipelined Wallace-tree multiplier: magnitudes -> carry-save reduction -> final add/negate.
// Define MUL_ACC_EN to add the acc port and a 2*WIDTH-bit multiply-accumulate register.
module pipelined_wallace_mult #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 3
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
`ifdef MUL_ACC_EN
    input  logic                 acc,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   z
);

    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("pipelined_wallace_mult: STAGES must be in 2..4");
    end
    if (WIDTH < 8 || WIDTH > 64) begin : g_bad_width
        $error("pipelined_wallace_mult: WIDTH must be in 8..64");
    end

    localparam int unsigned MID = (STAGES > 2) ? STAGES - 2 : 0;
    localparam logic [2*WIDTH-1:0] ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};

    // Reduces the WIDTH partial products to a sum/carry pair with 3:2 compressor levels.
    function automatic logic [4*WIDTH-1:0] wallace(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [2*WIDTH-1:0] row [WIDTH];
        logic [2*WIDTH-1:0] s, c;
        int unsigned cnt, k;
        for (int unsigned i = 0; i < WIDTH; i++)
            row[i] = y[i] ? ({{WIDTH{1'b0}}, x} << i) : '0;
        cnt = WIDTH;
        for (int unsigned lvl = 0; lvl < WIDTH; lvl++) begin
            if (cnt > 2) begin
                k = 0;
                for (int unsigned i = 0; i < WIDTH; i += 3) begin
                    if (i + 2 < cnt) begin
                        s = row[i] ^ row[i+1] ^ row[i+2];
                        c = ((row[i] & row[i+1]) | (row[i] & row[i+2]) | (row[i+1] & row[i+2])) << 1;
                        row[k]   = s;
                        row[k+1] = c;
                        k = k + 2;
                    end else if (i < cnt) begin
                        row[k] = row[i];
                        k = k + 1;
                        if (i + 1 < cnt) begin
                            row[k] = row[i+1];
                            k = k + 1;
                        end
                    end
                end
                cnt = k;
            end
        end
        return {row[0], row[1]};
    endfunction

    logic                 advance;
    logic                 s1_v_q, s1_v_d, s1_sg_q, s1_sg_d;
    logic [WIDTH-1:0]     s1_ma_q, s1_ma_d, s1_mb_q, s1_mb_d;
    logic [2*WIDTH-1:0]   red_s, red_c;
    logic                 fin_v, fin_sg;
    logic [2*WIDTH-1:0]   fin_s, fin_c, sum_sc, prod, res;
    logic                 out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0]   z_q, z_d;
`ifdef MUL_ACC_EN
    logic                 s1_ac_q, s1_ac_d, fin_ac;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
`endif

    assign advance   = !out_valid_q || out_ready;
    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign z         = z_q;

    always_comb begin
        s1_v_d  = s1_v_q;
        s1_sg_d = s1_sg_q;
        s1_ma_d = s1_ma_q;
        s1_mb_d = s1_mb_q;
`ifdef MUL_ACC_EN
        s1_ac_d = s1_ac_q;
`endif
        if (advance) begin
            s1_v_d  = in_valid;
            s1_sg_d = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            s1_ma_d = (signed_mode & a[WIDTH-1]) ? -a : a;
            s1_mb_d = (signed_mode & b[WIDTH-1]) ? -b : b;
`ifdef MUL_ACC_EN
            s1_ac_d = acc;
`endif
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            s1_v_q  <= 1'b0;
            s1_sg_q <= 1'b0;
            s1_ma_q <= '0;
            s1_mb_q <= '0;
`ifdef MUL_ACC_EN
            s1_ac_q <= 1'b0;
`endif
        end else begin
            s1_v_q  <= s1_v_d;
            s1_sg_q <= s1_sg_d;
            s1_ma_q <= s1_ma_d;
            s1_mb_q <= s1_mb_d;
`ifdef MUL_ACC_EN
            s1_ac_q <= s1_ac_d;
`endif
        end
    end

    assign {red_s, red_c} = wallace(s1_ma_q, s1_mb_q);

    if (MID == 0) begin : g_no_mid
        // Two-stage build: reduction and final add share the last register level.
        assign fin_v  = s1_v_q;
        assign fin_sg = s1_sg_q;
        assign fin_s  = red_s;
        assign fin_c  = red_c;
`ifdef MUL_ACC_EN
        assign fin_ac = s1_ac_q;
`endif
    end else begin : g_mid
        logic [MID-1:0]     v_q, v_d, sg_q, sg_d;
        logic [2*WIDTH-1:0] s_q [MID];
        logic [2*WIDTH-1:0] s_d [MID];
        logic [2*WIDTH-1:0] c_q [MID];
        logic [2*WIDTH-1:0] c_d [MID];
`ifdef MUL_ACC_EN
        logic [MID-1:0]     ac_q, ac_d;
`endif
        always_comb begin
            v_d  = v_q;
            sg_d = sg_q;
            s_d  = s_q;
            c_d  = c_q;
`ifdef MUL_ACC_EN
            ac_d = ac_q;
`endif
            if (advance) begin
                v_d[0]  = s1_v_q;
                sg_d[0] = s1_sg_q;
                s_d[0]  = red_s;
                c_d[0]  = red_c;
`ifdef MUL_ACC_EN
                ac_d[0] = s1_ac_q;
`endif
                for (int unsigned i = 1; i < MID; i++) begin
                    v_d[i]  = v_q[i-1];
                    sg_d[i] = sg_q[i-1];
                    s_d[i]  = s_q[i-1];
                    c_d[i]  = c_q[i-1];
`ifdef MUL_ACC_EN
                    ac_d[i] = ac_q[i-1];
`endif
                end
            end
        end

        always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
                v_q  <= '0;
                sg_q <= '0;
                s_q  <= '{default: '0};
                c_q  <= '{default: '0};
`ifdef MUL_ACC_EN
                ac_q <= '0;
`endif
            end else begin
                v_q  <= v_d;
                sg_q <= sg_d;
                s_q  <= s_d;
                c_q  <= c_d;
`ifdef MUL_ACC_EN
                ac_q <= ac_d;
`endif
            end
        end

        assign fin_v  = v_q[MID-1];
        assign fin_sg = sg_q[MID-1];
        assign fin_s  = s_q[MID-1];
        assign fin_c  = c_q[MID-1];
`ifdef MUL_ACC_EN
        assign fin_ac = ac_q[MID-1];
`endif
    end

    always_comb begin
        sum_sc = fin_s + fin_c;
        prod   = fin_sg ? (~sum_sc + ONE) : sum_sc;
`ifdef MUL_ACC_EN
        res    = prod + (fin_ac ? acc_q : '0);
        acc_d  = acc_q;
`else
        res    = prod;
`endif
        out_valid_d = out_valid_q;
        z_d         = z_q;
        if (advance) begin
            out_valid_d = fin_v;
            if (fin_v) begin
                z_d = res;
`ifdef MUL_ACC_EN
                acc_d = res;
`endif
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            out_valid_q <= 1'b0;
            z_q         <= '0;
`ifdef MUL_ACC_EN
            acc_q       <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            z_q         <= z_d;
`ifdef MUL_ACC_EN
            acc_q       <= acc_d;
`endif
        end
    end

endmodule

// File: tb/tb_pipelined_wallace_mult.sv
// Directed self-checking bench for pipelined_wallace_mult (WIDTH=32, STAGES=3).
module tb_pipelined_wallace_mult;

    logic        CLK;
    logic        RESET;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        signed_mode;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] z;
`ifdef MUL_ACC_EN
    logic        acc_in;
`endif

    int total = 0;
    int bad   = 0;

    logic        m_v [3];
    logic [63:0] m_z [3];
    logic [63:0] rcv [$];

    pipelined_wallace_mult #(.WIDTH(32), .STAGES(3)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
`ifdef MUL_ACC_EN
        .acc         (acc_in),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .z           (z)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One isolated beat with out_ready held high: expects out_valid exactly three edges later.
    task automatic one_beat(input string tag, input logic [31:0] x, input logic [31:0] y,
                            input logic sm, input logic [63:0] exp);
        a = x; b = y; signed_mode = sm; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        check({tag, "_lat1"}, {63'd0, out_valid}, 64'd0);
        tick();
        check({tag, "_lat2"}, {63'd0, out_valid}, 64'd0);
        tick();
        check({tag, "_lat3"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_z"}, z, exp);
        tick();
        check({tag, "_drain"}, {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        int sent;
        logic exp_rdy, accept;

        RESET = 1'b0; in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0; out_ready = 1'b1;
`ifdef MUL_ACC_EN
        acc_in = 1'b0;
`endif
        tick();
        tick();
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_z", z, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // First beat presented in the very first cycle after release.
        RESET = 1'b1;
        one_beat("neg3x7", 32'hFFFF_FFFD, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
        one_beat("ones_uns", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        one_beat("ones_sgn", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
        one_beat("minneg_sq", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        one_beat("zero_negb", 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0000);
        one_beat("minneg_x1", 32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000);
        one_beat("pow16_sq", 32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000);
        one_beat("5xneg1", 32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB);
        one_beat("big_uns", 32'h8000_0000, 32'h0000_0003, 1'b0, 64'h0000_0001_8000_0000);

        // Backpressure stream with out_ready pattern 1,0,0,1 against a slot-level model.
        for (int i = 0; i < 3; i++) begin
            m_v[i] = 1'b0;
            m_z[i] = '0;
        end
        sent = 0;
        for (int c = 0; c < 60 && rcv.size() < 8; c++) begin
            out_ready   = ((c % 4) == 0) || ((c % 4) == 3);
            in_valid    = (sent < 8);
            a           = 32'(sent);
            b           = 32'(sent + 1);
            signed_mode = 1'b0;
            #1;
            exp_rdy = !m_v[2] || out_ready;
            accept  = in_valid && exp_rdy;
            check("bp_in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
            check("bp_out_valid", {63'd0, out_valid}, {63'd0, m_v[2]});
            if (m_v[2] && out_ready) begin
                check("bp_z", z, m_z[2]);
                rcv.push_back(z);
            end
            if (exp_rdy) begin
                m_v[2] = m_v[1]; m_z[2] = m_z[1];
                m_v[1] = m_v[0]; m_z[1] = m_z[0];
                m_v[0] = accept; m_z[0] = 64'(sent * (sent + 1));
            end
            if (accept) sent++;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp_count", 64'(rcv.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < rcv.size()) check("bp_order", rcv[i], 64'(i * (i + 1)));
        end

        // Reset mid-operation: two beats in flight are discarded.
        a = 32'd10; b = 32'd10; signed_mode = 1'b0; in_valid = 1'b1;
        tick();
        a = 32'd11;
        tick();
        in_valid = 1'b0;
        RESET = 1'b0;
        #1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_z", z, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        RESET = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midrst_no_result", {63'd0, out_valid}, 64'd0);
        end

`ifdef MUL_ACC_EN
        a = 32'd2; b = 32'd3; acc_in = 1'b0; signed_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        a = 32'd4; b = 32'd5; acc_in = 1'b1;
        tick();
        a = 32'd1; b = 32'd1; acc_in = 1'b1;
        tick();
        in_valid = 1'b0; acc_in = 1'b0;
        check("mac_v0", {63'd0, out_valid}, 64'd1);
        check("mac_z0", z, 64'd6);
        tick();
        check("mac_v1", {63'd0, out_valid}, 64'd1);
        check("mac_z1", z, 64'd26);
        tick();
        check("mac_v2", {63'd0, out_valid}, 64'd1);
        check("mac_z2", z, 64'd27);
        tick();
        check("mac_drain", {63'd0, out_valid}, 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
